set_job_host: RTL



---
 rtl/set_host_pkg.sv | 32 +++
 rtl/set_job_fifo.sv | 64 ++++++
 rtl/set_job_host.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/set_host_pkg.sv
// Shared types and constants for the SET job host.
package set_host_pkg;

    localparam int unsigned COORD_W   = 4;
    localparam int unsigned CENTRAL_W = 6 * COORD_W;
    localparam int unsigned RADIUS_W  = 12;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned CNT_W     = 8;
    // Widest tag the descriptor can carry; the host uses the low TAG_W bits.
    localparam int unsigned TAG_MAX_W = 16;

    localparam logic [MODE_W-1:0] MODE_A   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AND = 2'd1;
    localparam logic [MODE_W-1:0] MODE_XOR = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TRI = 2'd3;

    typedef enum logic [2:0] {
        S_WAIT,
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
        logic [TAG_MAX_W-1:0] tag;
    } job_desc_t;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous FIFO of job descriptors; head is visible combinationally on data_o.
module set_job_fifo
    import set_host_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  job_desc_t data_i,
    input  logic      pop_i,
    output job_desc_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    job_desc_t        mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy update; pointers wrap naturally since Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared by synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/set_job_host.sv
// Initiator for the SET engine: queues job descriptors, issues them one at a time
// with a one-cycle en strobe, holds operands until set_valid, and returns results
// with a watchdog that aborts jobs the engine never finishes.
module set_job_host
    import set_host_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CENTRAL_W-1:0] job_central,
    input  logic [RADIUS_W-1:0]  job_radius,
    input  logic [MODE_W-1:0]    job_mode,
    input  logic [TAG_W-1:0]     job_tag,
    output logic                 en,
    output logic [CENTRAL_W-1:0] central,
    output logic [RADIUS_W-1:0]  radius,
    output logic [MODE_W-1:0]    mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CNT_W-1:0]     set_candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CNT_W-1:0]     res_count,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_timeout,
    output logic [15:0]          jobs_done
);

    localparam int unsigned    WdW    = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    job_desc_t        op_q, op_d;
    logic [WdW-1:0]   wdog_q, wdog_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_timeout_q, res_timeout_d;
    logic [15:0]      jobs_done_q, jobs_done_d;

    job_desc_t        job_in;
    job_desc_t        fifo_head;
    logic             fifo_full, fifo_empty, fifo_pop;

    // Pack the incoming descriptor; unused tag bits are zero.
    always_comb begin
        job_in                = '0;
        job_in.central        = job_central;
        job_in.radius         = job_radius;
        job_in.mode           = job_mode;
        job_in.tag[TAG_W-1:0] = job_tag;
    end

    assign job_ready = !fifo_full;

    set_job_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (job_valid),
        .data_i  (job_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    if (TAG_W < TAG_MAX_W) begin : g_tag_pad
        logic unused_tag_pad;
        assign unused_tag_pad = ^op_q.tag[TAG_MAX_W-1:TAG_W];
    end

    // Job sequencing FSM: next state, FIFO pop, operand capture and result capture.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wdog_d        = wdog_q;
        res_count_d   = res_count_q;
        res_tag_d     = res_tag_q;
        res_timeout_d = res_timeout_q;
        jobs_done_d   = jobs_done_q;
        fifo_pop      = 1'b0;
        unique case (state_q)
            // Give SET one cycle after reset to settle into its read state.
            S_WAIT: state_d = S_IDLE;
            S_IDLE: begin
                if (!fifo_empty && !set_busy) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // wdog_d counts HOLD cycles including this one, so the abort
                // lands the result exactly TIMEOUT cycles after en.
                wdog_d = wdog_q + WdW'(1);
                if (set_valid) begin
                    res_count_d   = set_candidate;
                    res_tag_d     = op_q.tag[TAG_W-1:0];
                    res_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (wdog_d == WdLast) begin
                    res_count_d   = '0;
                    res_tag_d     = op_q.tag[TAG_W-1:0];
                    res_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_WAIT;
            op_q          <= '0;
            wdog_q        <= '0;
            res_count_q   <= '0;
            res_tag_q     <= '0;
            res_timeout_q <= 1'b0;
            jobs_done_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wdog_q        <= wdog_d;
            res_count_q   <= res_count_d;
            res_tag_q     <= res_tag_d;
            res_timeout_q <= res_timeout_d;
            jobs_done_q   <= jobs_done_d;
        end
    end

    assign en          = (state_q == S_ISSUE);
    assign res_valid   = (state_q == S_RESP);
    assign central     = op_q.central;
    assign radius      = op_q.radius;
    assign mode        = op_q.mode;
    assign res_count   = res_count_q;
    assign res_tag     = res_tag_q;
    assign res_timeout = res_timeout_q;
    assign jobs_done   = jobs_done_q;

endmodule
